// File: rtl/bnn_weight_loader.sv
// -----------------------------------------------------------------------------
// bnn_weight_loader
//
// Framed nibble-stream weight loader for the 8-8-4 BNN core. A frame is a sync
// nibble followed by two nibbles per neuron (low half first). The two nibbles
// for a neuron are assembled into a shadow buffer. When the frame is complete,
// the whole buffer is committed to the core as a burst of per-neuron write
// strobes. A partial or corrupted frame never reaches the core because nothing
// is written until the full frame has been received and, optionally, verified.
//
// Optional feature macro: BNN_WLOAD_CHECKSUM_EN
//   defined     : the frame carries one trailing XOR checksum nibble. On a
//                 mismatch, err pulses, err_sticky is set and the frame is
//                 dropped.
//   not defined : there is no checksum nibble. The last data nibble moves
//                 straight to commit. err and err_sticky are tied 0.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   global enable; when low, everything holds and pulses are low
//   nib_in     in   [3:0] nibble data
//   nib_valid  in   nibble qualifier
//   w_wr_en    out  weight write strobe to the core
//   w_addr     out  [3:0] neuron index of the current write
//   w_data     out  [7:0] weight value of the current write
//   busy       out  high whenever the loader is not idle
//   done       out  one-cycle pulse after the last commit write
//   err        out  one-cycle pulse on checksum mismatch
//   err_sticky out  set by err, cleared by the next done or by reset
// -----------------------------------------------------------------------------
module bnn_weight_loader #(
    parameter int         NUM_NEURONS = 12,
    parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    output logic       w_wr_en,
    output logic [3:0] w_addr,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       err_sticky
);

    // The counter must be able to hold 0..2*NUM_NEURONS.
    localparam int CNT_W = $clog2(2 * NUM_NEURONS + 1);
    // Width of the neuron index. It is wide enough to reach NUM_NEURONS-1.
    localparam int IDX_W = CNT_W - 1;

    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(2 * NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] COMMIT_END    = CNT_W'(NUM_NEURONS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_CSUM   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [3:0]         r_low;
    logic [3:0]         w_low_next;

    logic               r_wr_en;
    logic               w_wr_en_next;
    logic [3:0]         r_addr;
    logic [3:0]         w_addr_next;
    logic [7:0]         r_data;
    logic               r_busy;
    logic               r_done;
    logic               w_done_next;

    logic               w_accept;
    logic               w_last_data;
    logic               w_commit_end;
    logic               w_data_wr;      // high-half nibble completes a shadow entry
    logic               w_rd_en;        // load w_data from the shadow buffer

    logic [NUM_NEURONS-1:0] w_shadow_we;
    logic [7:0]             w_shadow [NUM_NEURONS];

`ifdef BNN_WLOAD_CHECKSUM_EN
    logic [3:0]         r_csum;
    logic [3:0]         w_csum_next;
    logic               w_csum_ok;
    logic               r_err;
    logic               w_err_next;
    logic               r_err_sticky;
    logic               w_sticky_next;

    assign w_csum_ok = (nib_in == r_csum);
`endif

    assign w_accept     = ena && nib_valid;
    assign w_last_data  = (r_cnt == LAST_DATA_CNT);
    assign w_commit_end = (r_cnt == COMMIT_END);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. If ena is low, the FSM is frozen.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (nib_valid && (nib_in == SYNC_NIBBLE)) begin
                        w_state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (nib_valid && w_last_data) begin
`ifdef BNN_WLOAD_CHECKSUM_EN
                        w_state_next = S_CSUM;
`else
                        w_state_next = S_COMMIT;
`endif
                    end
                end
`ifdef BNN_WLOAD_CHECKSUM_EN
                S_CSUM: begin
                    if (nib_valid) begin
                        w_state_next = w_csum_ok ? S_COMMIT : S_IDLE;
                    end
                end
`endif
                S_COMMIT: begin
                    if (w_commit_end) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next-value logic.
    // The counter is shared. It counts data nibbles in DATA and write
    // addresses in COMMIT. Pulses default low, so they are forced low while
    // ena is low; all other values hold.
    // -------------------------------------------------------------------------
    always_comb begin
        w_cnt_next   = r_cnt;
        w_low_next   = r_low;
        w_wr_en_next = 1'b0;
        w_addr_next  = r_addr;
        w_done_next  = 1'b0;
        w_data_wr    = 1'b0;
        w_rd_en      = 1'b0;
`ifdef BNN_WLOAD_CHECKSUM_EN
        w_csum_next   = r_csum;
        w_err_next    = 1'b0;
        w_sticky_next = r_err_sticky;
`endif
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (nib_valid && (nib_in == SYNC_NIBBLE)) begin
                        w_cnt_next = '0;
`ifdef BNN_WLOAD_CHECKSUM_EN
                        w_csum_next = 4'h0;
`endif
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef BNN_WLOAD_CHECKSUM_EN
                        w_csum_next = r_csum ^ nib_in;
`endif
                        if (r_cnt[0] == 1'b0) begin
                            w_low_next = nib_in;
                        end else begin
                            w_data_wr = 1'b1;
                        end
                        w_cnt_next = w_last_data ? '0 : (r_cnt + CNT_W'(1));
                    end
                end
`ifdef BNN_WLOAD_CHECKSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        w_cnt_next = '0;
                        if (!w_csum_ok) begin
                            w_err_next    = 1'b1;
                            w_sticky_next = 1'b1;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    if (!w_commit_end) begin
                        w_wr_en_next = 1'b1;
                        w_addr_next  = 4'(r_cnt);
                        w_rd_en      = 1'b1;
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end else begin
                        // The cycle after the last strobe closes the burst.
                        w_done_next = 1'b1;
                        w_cnt_next  = '0;
`ifdef BNN_WLOAD_CHECKSUM_EN
                        w_sticky_next = 1'b0;
`endif
                    end
                end
                default: begin
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_low   <= 4'h0;
            r_wr_en <= 1'b0;
            r_addr  <= 4'h0;
            r_data  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_low   <= w_low_next;
            r_wr_en <= w_wr_en_next;
            r_addr  <= w_addr_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= w_done_next;
            // Registered read of the shadow buffer. It stays aligned with the
            // strobe and address.
            if (w_rd_en) begin
                r_data <= w_shadow[r_cnt[IDX_W-1:0]];
            end
        end
    end

`ifdef BNN_WLOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum       <= 4'h0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_csum       <= w_csum_next;
            r_err        <= w_err_next;
            r_err_sticky <= w_sticky_next;
        end
    end

    assign err        = r_err;
    assign err_sticky = r_err_sticky;
`else
    assign err        = 1'b0;
    assign err_sticky = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Shadow buffer: one 8-bit entry per neuron. It is never cleared between
    // frames, because every commit rewrites all entries.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_shadow
            logic [7:0] r_entry;

            assign w_shadow_we[gi] = w_data_wr &&
                                     (r_cnt[CNT_W-1:1] == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= 8'h00;
                end else if (w_shadow_we[gi]) begin
                    r_entry <= {nib_in, r_low};
                end
            end

            assign w_shadow[gi] = r_entry;
        end
    endgenerate

    assign w_wr_en = r_wr_en;
    assign w_addr  = r_addr;
    assign w_data  = r_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_bnn_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_bnn_weight_loader
//
// Directed testbench for bnn_weight_loader. The checksum-specific steps run
// only when BNN_WLOAD_CHECKSUM_EN is defined. All other steps run in both
// builds.
// -----------------------------------------------------------------------------
module tb_bnn_weight_loader;

    localparam int NUM = 12;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] nib_in;
    logic       nib_valid;
    logic       w_wr_en;
    logic [3:0] w_addr;
    logic [7:0] w_data;
    logic       busy;
    logic       done;
    logic       err;
    logic       err_sticky;

    int checks;
    int errors;

    logic [7:0] exp_w [NUM];

    bnn_weight_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .nib_in     (nib_in),
        .nib_valid  (nib_valid),
        .w_wr_en    (w_wr_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one nibble from the falling edge. The nibble is accepted at the
    // next rising edge. The task returns 1 time unit after that edge.
    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        nib_in    = n;
        nib_valid = 1'b1;
        @(posedge clk);
        #1;
        nib_valid = 1'b0;
    endtask

    // Send the sync nibble and the data nibbles built from exp_w (low half
    // first). With the checksum build, also send the checksum nibble.
    task automatic send_frame(input logic [3:0] csum);
        send_nib(4'hA);
        check("busy_after_sync", busy, 1);
        for (int k = 0; k < NUM; k++) begin
            send_nib(exp_w[k][3:0]);
            send_nib(exp_w[k][7:4]);
        end
`ifdef BNN_WLOAD_CHECKSUM_EN
        send_nib(csum);
`else
        if (csum === 4'hx) $display("note: checksum argument unused");
`endif
    endtask

    // XOR of all data nibbles of exp_w.
    function automatic logic [3:0] calc_csum();
        logic [3:0] c;
        c = 4'h0;
        for (int k = 0; k < NUM; k++) c = c ^ exp_w[k][3:0] ^ exp_w[k][7:4];
        return c;
    endfunction

    // Call this right after the final frame nibble has been accepted. It
    // checks each cycle of the commit burst. If pause_at is an address, ena is
    // dropped for 3 cycles after that address has been written.
    task automatic run_commit(input int pause_at);
        $display("commit: entry busy=%0d wr_en=%0d", busy, w_wr_en);
        check("commit_entry_busy", busy, 1);
        check("commit_entry_wr_en", w_wr_en, 0);
        for (int k = 0; k < NUM; k++) begin
            @(posedge clk);
            #1;
            $display("commit: wr_en=%0d addr=%0d data=0x%02h", w_wr_en, w_addr, w_data);
            check($sformatf("wr_en_k%0d", k), w_wr_en, 1);
            check($sformatf("addr_k%0d", k), w_addr, k);
            check($sformatf("data_k%0d", k), w_data, exp_w[k]);
            check($sformatf("busy_k%0d", k), busy, 1);
            check($sformatf("done_k%0d", k), done, 0);
            check($sformatf("err_k%0d", k), err, 0);
            if (k == pause_at) begin
                ena = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    @(posedge clk);
                    #1;
                    $display("pause: wr_en=%0d addr=%0d", w_wr_en, w_addr);
                    check($sformatf("pause_wr_en_%0d", p), w_wr_en, 0);
                    check($sformatf("pause_addr_%0d", p), w_addr, k);
                    check($sformatf("pause_busy_%0d", p), busy, 1);
                end
                ena = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        $display("commit: end wr_en=%0d done=%0d busy=%0d sticky=%0d", w_wr_en, done, busy, err_sticky);
        check("end_wr_en", w_wr_en, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_err_sticky", err_sticky, 0);
    endtask

    initial begin
        logic [3:0] junk [7];
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        nib_in    = 4'h0;
        nib_valid = 1'b0;
        junk      = '{4'h0, 4'h5, 4'hF, 4'h3, 4'hB, 4'h1, 4'h9};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        $display("reset: wr_en=%0d busy=%0d done=%0d err=%0d sticky=%0d", w_wr_en, busy, done, err, err_sticky);
        check("rst_wr_en", w_wr_en, 0);
        check("rst_addr", w_addr, 0);
        check("rst_data", w_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_sticky", err_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-sync nibbles in idle are ignored
        for (int i = 0; i < 7; i++) begin
            send_nib(junk[i]);
            $display("idle junk 0x%0h: busy=%0d wr_en=%0d", junk[i], busy, w_wr_en);
            check($sformatf("idle_busy_%0d", i), busy, 0);
            check($sformatf("idle_wr_en_%0d", i), w_wr_en, 0);
        end
        // A sync value without nib_valid is ignored
        @(negedge clk);
        nib_in = 4'hA;
        @(posedge clk);
        #1;
        check("sync_no_valid_busy", busy, 0);
        // A sync nibble while ena is low is ignored
        ena = 1'b0;
        send_nib(4'hA);
        check("sync_ena_low_busy", busy, 0);
        ena = 1'b1;

        // Frame 1: neuron 0 = 0x5A, the rest 0; hand checksum A^5 = F
        for (int k = 0; k < NUM; k++) exp_w[k] = 8'h00;
        exp_w[0] = 8'h5A;
        send_frame(4'hF);
        run_commit(-1);
        @(posedge clk);
        #1;
        check("f1_done_drop", done, 0);
        check("f1_idle_busy", busy, 0);

`ifdef BNN_WLOAD_CHECKSUM_EN
        // Same frame with a wrong checksum: err pulse, sticky, no writes
        send_frame(4'h0);
        $display("bad csum: err=%0d sticky=%0d busy=%0d wr_en=%0d", err, err_sticky, busy, w_wr_en);
        check("bad_err", err, 1);
        check("bad_sticky", err_sticky, 1);
        check("bad_busy", busy, 0);
        check("bad_wr_en", w_wr_en, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bad_after_wr_en_%0d", i), w_wr_en, 0);
            check($sformatf("bad_after_err_%0d", i), err, 0);
            check($sformatf("bad_after_sticky_%0d", i), err_sticky, 1);
        end
`endif

        // Frame 2: neuron k = {k, ~k}. Neuron 5 carries the sync value as data.
        // The commit pauses at address 4.
        for (int k = 0; k < NUM; k++) exp_w[k] = {4'(k), ~4'(k)};
        send_frame(calc_csum());
        run_commit(4);

        // Frame 3 is sent back-to-back: its sync is presented in the done cycle.
        for (int k = 0; k < NUM; k++) exp_w[k] = 8'(k * 37 + 1);
        send_frame(calc_csum());
        run_commit(-1);

        // Reset in the middle of a frame drops the frame
        send_nib(4'hA);
        for (int i = 0; i < 10; i++) send_nib(4'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("mid reset: busy=%0d wr_en=%0d done=%0d", busy, w_wr_en, done);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", w_wr_en, 0);
        check("midrst_done", done, 0);
        check("midrst_err_sticky", err_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_idle_wr_en", w_wr_en, 0);

        // Frame 4: all-F data; hand checksum is 0 (24 F nibbles)
        for (int k = 0; k < NUM; k++) exp_w[k] = 8'hFF;
        send_frame(4'h0);
        run_commit(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
